main_mem: RTL and testbench
===========================

MAIN_MEM -- requirements
Module: main_mem

Interface
REQ-001 Parameter BASE_ADDR, 32'h8002_0000, byte address of memory word 0.
REQ-002 Parameter DEPTH_WORDS, 262144, number of 32-bit words (1 MiB).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 addr  in  32 [0:31]  byte address; sampled only at request acceptance.
REQ-006 data_in  in  32 [0:31]  write data, one word per cycle during writes.
REQ-007 data_out  out  32 [0:31]  read data, registered.
REQ-008 acc_size  in  2 [0:1]  burst length: 00=1, 01=4, 10=8, 11=16 words.
REQ-009 wren  in  1  1=write request, 0=read request.
REQ-010 busy  out  1  high while a multi-cycle transaction is in progress.
REQ-011 enable  in  1  request qualifier; low aborts/blocks transactions.

Function
REQ-012 Request accepted at a rising edge when enable=1 and busy=0; addr, wren, acc_size latched then.
REQ-013 Word index = (addr - BASE_ADDR) >> 2; addr[30:31] ignored; burst word i uses index + i.
REQ-014 Index >= DEPTH_WORDS or addr < BASE_ADDR: write word dropped, read word returns 32'h0.
REQ-015 Write of N words: word 0 = data_in at accept edge k; word i = data_in at edge k+i.
REQ-016 Write busy: high after edge k when N>1; low after edge k+N-1; single write leaves busy low.
REQ-017 Read of N words: word i on data_out after edge k+1+i, stable one full cycle each.
REQ-018 Read busy: high after edge k; low after edge k+N.
REQ-019 Next request accepted at first edge with busy=0, back-to-back allowed.
REQ-020 Read-after-write to the same word returns the new value, no stale-data hazard.
REQ-021 data_out holds its last value when no read word is being driven.
REQ-022 States: IDLE, WRITE (remaining words), RD_WAIT (one-cycle latency), READ (remaining words); IDLE->WRITE/RD_WAIT on accept, RD_WAIT->READ, WRITE/READ->IDLE after last word.
REQ-023 enable=0 at any edge while busy: current transaction aborted, no further words written or driven, state->IDLE, busy low after that edge.
REQ-024 Bursts do not wrap; words past top of memory follow REQ-014.
REQ-025 Inputs other than enable ignored while busy=1.

Reset
REQ-026 reset_n low: immediately state=IDLE, busy=0, data_out=32'h0, burst counters 0.
REQ-027 Memory contents not reset; reset mid-transaction discards remaining words, already-written words retained.
REQ-028 reset_n release: first request accepted at first rising edge with reset_n=1.

Structure
REQ-029 Package main_mem_pkg: acc_size encodings, burst-length function, state enum, BASE_ADDR default.
REQ-030 Sub-module main_mem_array: single-port synchronous word RAM, DEPTH_WORDS x 32, one read or write per cycle.
REQ-031 Control FSM, address/index arithmetic and out-of-range checks in main_mem.

Verification
REQ-032 Single write 0x8002_0000 <- 55cc55cc, then single read -> data_out=55cc55cc after second edge post-accept, busy high one cycle.
REQ-033 4-word write at 0x8002_0004 (55cc55cd, 55cc55ce, 55cc55cf, 55cc55c1), then 4-word read at 0x8002_0000 -> 55cc55cc, 55cc55cd, 55cc55ce, 55cc55cf on consecutive cycles.
REQ-034 16-word read from BASE_ADDR + 4*(DEPTH_WORDS-2) -> 2 stored words, then 14 zeros; writes there leave memory unchanged.
REQ-035 enable dropped during word 2 of an 8-word write -> words 0-1 written, words 2-7 unchanged, busy low next cycle.
REQ-036 reset_n asserted mid 4-word read -> busy=0, data_out=0 immediately; earlier writes still readable after release.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared encodings and defaults for the main_mem word memory.
package main_mem_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h8002_0000;
  localparam int          DEPTH_WORDS_DEF = 262144;

  localparam logic [1:0] ACC_1  = 2'b00;
  localparam logic [1:0] ACC_4  = 2'b01;
  localparam logic [1:0] ACC_8  = 2'b10;
  localparam logic [1:0] ACC_16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_READ    = 2'd3
  } state_t;

  function automatic logic [4:0] burst_len(input logic [1:0] acc);
    logic [4:0] len;
    case (acc)
      ACC_1:   len = 5'd1;
      ACC_4:   len = 5'd4;
      ACC_8:   len = 5'd8;
      default: len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port synchronous word RAM: one write or one read per cycle.
// Read data appears one cycle after the read strobe and holds until the next read.
module main_mem_array #(
  parameter int DEPTH_WORDS = 262144,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_mem.sv
// Burst word memory: writes take one word per cycle from the accept edge, reads
// return word 0 two edges after accept; busy blocks new requests, enable low aborts.
module main_mem
  import main_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [0:31] addr,
  input  logic [0:31] data_in,
  output logic [0:31] data_out,
  input  logic [0:1]  acc_size,
  input  logic        wren,
  output logic        busy,
  input  logic        enable
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] widx_q, widx_d;
  logic        below_q, below_d;
  logic        rd_oor_q, rd_oor_d;
  logic [31:0] dout_q, dout_d;

  logic [31:0]   addr_off;
  logic [31:0]   req_idx;
  logic          req_below;
  logic          req_oor;
  logic          cur_oor;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // Index arithmetic is full width so out-of-range words never alias onto real RAM rows.
  always_comb begin
    addr_off  = addr - BASE_ADDR;
    req_idx   = addr_off >> 2;
    req_below = (addr < BASE_ADDR);
    req_oor   = req_below || (req_idx >= 32'(DEPTH_WORDS));
    cur_oor   = below_q || (widx_q >= 32'(DEPTH_WORDS));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    below_d  = below_q;
    rd_oor_d = rd_oor_q;
    dout_d   = dout_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = widx_q[AW-1:0];
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          below_d  = req_below;
          widx_d   = req_idx + 32'd1;
          ram_addr = req_idx[AW-1:0];
          if (wren) begin
            ram_we  = !req_oor;
            cnt_d   = burst_len(acc_size) - 5'd1;
            state_d = (acc_size == ACC_1) ? ST_IDLE : ST_WRITE;
          end else begin
            ram_re   = 1'b1;
            rd_oor_d = req_oor;
            cnt_d    = burst_len(acc_size);
            state_d  = ST_RD_WAIT;
          end
        end
      end
      ST_WRITE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else begin
          ram_we = !cur_oor;
          widx_d = widx_q + 32'd1;
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT, ST_READ: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else begin
          // Present the word fetched last cycle and prefetch the next one if any remain.
          dout_d = rd_oor_q ? 32'h0 : ram_rdata;
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_READ;
            ram_re   = 1'b1;
            rd_oor_d = cur_oor;
            widx_d   = widx_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      widx_q   <= 32'd0;
      below_q  <= 1'b0;
      rd_oor_q <= 1'b0;
      dout_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      below_q  <= below_d;
      rd_oor_q <= rd_oor_d;
      dout_q   <= dout_d;
    end
  end

  main_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  assign busy     = (state_q != ST_IDLE);
  assign data_out = dout_q;

endmodule

// File: tb/tb_main_mem.sv
// Directed bench for main_mem: bursts, range limits, aborts and reset behaviour.
module tb_main_mem;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 262144;
  localparam logic [31:0] TOP   = 32'h8011_FFF8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [0:31] addr;
  logic [0:31] data_in;
  logic [0:31] data_out;
  logic [0:1]  acc_size;
  logic        wren;
  logic        busy;
  logic        enable;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_buf [16];
  logic [31:0] rd_buf [16];
  logic        wr_busy_first, wr_busy_last;
  logic        rd_busy_first, rd_busy_last;

  main_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .acc_size (acc_size),
    .wren     (wren),
    .busy     (busy),
    .enable   (enable)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [1:0] acc, input int n);
    enable   = 1'b1;
    wren     = 1'b1;
    addr     = a;
    acc_size = acc;
    data_in  = wr_buf[0];
    tick();
    wr_busy_first = busy;
    addr     = 32'h0;
    wren     = 1'b0;
    acc_size = 2'b11;
    for (int i = 1; i < n; i++) begin
      data_in = wr_buf[i];
      tick();
    end
    enable = 1'b0;
    wr_busy_last = busy;
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [1:0] acc, input int n);
    enable   = 1'b1;
    wren     = 1'b0;
    addr     = a;
    acc_size = acc;
    tick();
    rd_busy_first = busy;
    wren     = 1'b1;
    addr     = 32'h0;
    data_in  = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      tick();
      rd_buf[i] = data_out;
    end
    enable = 1'b0;
    wren   = 1'b0;
    rd_busy_last = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; wren = 1'b0;
    addr = 32'h0; data_in = 32'h0; acc_size = 2'b00;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++;
    if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 00000000", data_out); end
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_rw();
    wr_buf[0] = 32'h55cc_55cc;
    wr_burst(BASE, 2'b00, 1);
    tests++;
    if (wr_busy_first !== 1'b0) begin fails++; $display("FAIL single_wr_busy got %b exp 0", wr_busy_first); end
    rd_burst(BASE, 2'b00, 1);
    tests++;
    if (rd_busy_first !== 1'b1) begin fails++; $display("FAIL single_rd_busy got %b exp 1", rd_busy_first); end
    tests++;
    if (rd_buf[0] !== 32'h55cc_55cc) begin fails++; $display("FAIL single_rd_data got %h exp 55cc55cc", rd_buf[0]); end
    tests++;
    if (rd_busy_last !== 1'b0) begin fails++; $display("FAIL single_rd_busy_end got %b exp 0", rd_busy_last); end
    rd_burst(BASE + 32'd3, 2'b00, 1);
    tests++;
    if (rd_buf[0] !== 32'h55cc_55cc) begin fails++; $display("FAIL low_bits_ignored got %h exp 55cc55cc", rd_buf[0]); end
  endtask

  task automatic test_burst4();
    logic [31:0] exp [4];
    exp[0] = 32'h55cc_55cc; exp[1] = 32'h55cc_55cd; exp[2] = 32'h55cc_55ce; exp[3] = 32'h55cc_55cf;
    wr_buf[0] = 32'h55cc_55cd; wr_buf[1] = 32'h55cc_55ce;
    wr_buf[2] = 32'h55cc_55cf; wr_buf[3] = 32'h55cc_55c1;
    wr_burst(BASE + 32'd4, 2'b01, 4);
    tests++;
    if (wr_busy_first !== 1'b1) begin fails++; $display("FAIL burst_wr_busy got %b exp 1", wr_busy_first); end
    tests++;
    if (wr_busy_last !== 1'b0) begin fails++; $display("FAIL burst_wr_busy_end got %b exp 0", wr_busy_last); end
    rd_burst(BASE, 2'b01, 4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_buf[i] !== exp[i]) begin fails++; $display("FAIL burst_rd_word%0d got %h exp %h", i, rd_buf[i], exp[i]); end
    end
    tests++;
    if (rd_busy_last !== 1'b0) begin fails++; $display("FAIL burst_rd_busy_end got %b exp 0", rd_busy_last); end
  endtask

  task automatic test_top_boundary();
    logic [31:0] exp;
    wr_buf[0] = 32'ha0a0_0000; wr_buf[1] = 32'ha1a1_0001;
    wr_buf[2] = 32'hb2b2_0002; wr_buf[3] = 32'hb3b3_0003;
    wr_burst(TOP, 2'b01, 4);
    rd_burst(TOP, 2'b11, 16);
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? 32'ha0a0_0000 : (i == 1) ? 32'ha1a1_0001 : 32'h0;
      tests++;
      if (rd_buf[i] !== exp) begin fails++; $display("FAIL top_rd_word%0d got %h exp %h", i, rd_buf[i], exp); end
    end
    rd_burst(BASE, 2'b00, 1);
    tests++;
    if (rd_buf[0] !== 32'h55cc_55cc) begin fails++; $display("FAIL top_no_wrap got %h exp 55cc55cc", rd_buf[0]); end
    wr_buf[0] = 32'hdead_beef;
    wr_burst(BASE - 32'd4, 2'b00, 1);
    rd_burst(TOP + 32'd4, 2'b00, 1);
    tests++;
    if (rd_buf[0] !== 32'ha1a1_0001) begin fails++; $display("FAIL below_base_alias got %h exp a1a10001", rd_buf[0]); end
    rd_burst(BASE - 32'd4, 2'b00, 1);
    tests++;
    if (rd_buf[0] !== 32'h0) begin fails++; $display("FAIL below_base_read got %h exp 00000000", rd_buf[0]); end
  endtask

  task automatic test_abort_write();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) wr_buf[i] = 32'h1000_0000 + 32'(i);
    wr_burst(BASE + 32'h40, 2'b10, 8);
    enable = 1'b1; wren = 1'b1; addr = BASE + 32'h40; acc_size = 2'b10;
    data_in = 32'h2000_0000;
    tick();
    data_in = 32'h2000_0001;
    tick();
    data_in = 32'h2000_0002;
    enable  = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_wr_busy got %b exp 0", busy); end
    data_in = 32'h2000_0003;
    tick();
    rd_burst(BASE + 32'h40, 2'b10, 8);
    for (int i = 0; i < 8; i++) begin
      exp = (i < 2) ? 32'h2000_0000 + 32'(i) : 32'h1000_0000 + 32'(i);
      tests++;
      if (rd_buf[i] !== exp) begin fails++; $display("FAIL abort_wr_word%0d got %h exp %h", i, rd_buf[i], exp); end
    end
  endtask

  task automatic test_abort_read();
    enable = 1'b1; wren = 1'b0; addr = BASE + 32'd4; acc_size = 2'b01;
    tick();
    tick();
    tests++;
    if (data_out !== 32'h55cc_55cd) begin fails++; $display("FAIL abort_rd_word0 got %h exp 55cc55cd", data_out); end
    enable = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_rd_busy got %b exp 0", busy); end
    tick();
    tests++;
    if (data_out !== 32'h55cc_55cd) begin fails++; $display("FAIL abort_rd_hold got %h exp 55cc55cd", data_out); end
  endtask

  task automatic test_back_to_back();
    wr_buf[0] = 32'hcafe_0001;
    wr_burst(BASE + 32'h100, 2'b00, 1);
    rd_burst(BASE + 32'h100, 2'b00, 1);
    tests++;
    if (rd_buf[0] !== 32'hcafe_0001) begin fails++; $display("FAIL b2b_single got %h exp cafe0001", rd_buf[0]); end
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'hbeef_0010 + 32'(i);
    wr_burst(BASE + 32'h100, 2'b01, 4);
    rd_burst(BASE + 32'h100, 2'b01, 4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_buf[i] !== 32'hbeef_0010 + 32'(i)) begin
        fails++; $display("FAIL b2b_burst_word%0d got %h exp %h", i, rd_buf[i], 32'hbeef_0010 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] exp [4];
    exp[0] = 32'h55cc_55cc; exp[1] = 32'h55cc_55cd; exp[2] = 32'h55cc_55ce; exp[3] = 32'h55cc_55cf;
    enable = 1'b1; wren = 1'b0; addr = BASE; acc_size = 2'b01;
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    tests++;
    if (data_out !== 32'h0) begin fails++; $display("FAIL rst_mid_data got %h exp 00000000", data_out); end
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    rd_burst(BASE, 2'b01, 4);
    tests++;
    if (rd_busy_first !== 1'b1) begin fails++; $display("FAIL rst_release_accept got %b exp 1", rd_busy_first); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_buf[i] !== exp[i]) begin fails++; $display("FAIL rst_after_word%0d got %h exp %h", i, rd_buf[i], exp[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rw();
    test_burst4();
    test_top_boundary();
    test_abort_write();
    test_abort_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
